// File: rtl/reciprocal_divider.sv
// reciprocal_divider
//   Restoring shift-subtract divider with a 4-phase req/ack handshake.
//   mode=0 : x_inv = floor(2^(2N-1) / x), rem = 2^(2N-1) mod x
//   mode=1 : x_inv = floor((a << N) / x), rem = (a << N) mod x
//   BPC quotient bits are resolved per CALC cycle; a result appears
//   2N/BPC edges after the capture edge. x=0 completes at once with err=1.
//
// Ports
//   clock  : clock, rising edge
//   rst    : asynchronous active-high reset
//   req    : operation request (4-phase handshake)
//   mode   : 0 = reciprocal, 1 = division
//   a      : dividend (mode=1 only)
//   x      : unsigned divisor
//   x_inv  : quotient (2N bits)
//   rem    : remainder (N bits)
//   ack    : result valid / handshake acknowledge
//   busy   : high while computing
//   err    : divide-by-zero flag, valid while ack=1
module reciprocal_divider #(
  parameter int N   = 8,
  parameter int BPC = 1
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           req,
  input  logic           mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   x,
  output logic [2*N-1:0] x_inv,
  output logic [N-1:0]   rem,
  output logic           ack,
  output logic           busy,
  output logic           err
);

  localparam int          STEPS = (2 * N) / BPC;
  localparam int          CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  localparam int unsigned BPC_U = BPC;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_x;
  // Numerator bits leave at the top while quotient bits enter at the bottom;
  // after 2N steps the register holds the quotient only.
  logic [2*N-1:0]  r_nq;
  // Partial remainder already shifted left with the next numerator bit
  // appended, i.e. the value about to be compared against the divisor.
  logic [N:0]      r_cand;

  logic [2*N-1:0]  w_num;
  logic [2*N-1:0]  w_nq;
  logic [N:0]      w_cand;
  logic [N-1:0]    w_rem;
  logic            w_qbit;

  assign w_num = mode ? {a, {N{1'b0}}} : {1'b1, {(2*N-1){1'b0}}};

  // BPC restoring steps chained combinationally.
  always_comb begin
    w_nq   = r_nq;
    w_cand = r_cand;
    w_rem  = '0;
    w_qbit = 1'b0;
    for (int unsigned i = 0; i < BPC_U; i++) begin
      if (w_cand >= {1'b0, r_x}) begin
        w_rem  = N'(w_cand - {1'b0, r_x});
        w_qbit = 1'b1;
      end else begin
        w_rem  = w_cand[N-1:0];
        w_qbit = 1'b0;
      end
      w_cand = {w_rem, w_nq[2*N-1]};
      w_nq   = {w_nq[2*N-2:0], w_qbit};
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_nq    <= '0;
      r_cand  <= '0;
      x_inv   <= '0;
      rem     <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req) begin
            r_x    <= x;
            r_cnt  <= '0;
            r_nq   <= {w_num[2*N-2:0], 1'b0};
            r_cand <= {{N{1'b0}}, w_num[2*N-1]};
            if (x == '0) begin
              r_state <= DONE;
              ack     <= 1'b1;
              err     <= 1'b1;
              x_inv   <= '1;
              rem     <= '0;
            end else begin
              r_state <= CALC;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!req) begin
            // Abort: previous results stay on the outputs.
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_nq   <= w_nq;
            r_cand <= w_cand;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_state <= DONE;
              busy    <= 1'b0;
              ack     <= 1'b1;
              err     <= 1'b0;
              x_inv   <= w_nq;
              rem     <= w_rem;
            end
          end
        end
        DONE: begin
          if (!req) begin
            r_state <= IDLE;
            ack     <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          ack     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reciprocal_divider.sv
// Testbench for reciprocal_divider: three instances (BPC = 1, 2, 4) share
// the data inputs and each has its own req. Results are compared against a
// plain-arithmetic model.
module tb_reciprocal_divider;

  localparam int N  = 8;
  localparam int NI = 3;

  logic           clock = 1'b0;
  logic           rst;
  logic           mode;
  logic [N-1:0]   a;
  logic [N-1:0]   x;
  logic           req_v  [NI];
  logic [2*N-1:0] xinv_v [NI];
  logic [N-1:0]   rem_v  [NI];
  logic           ack_v  [NI];
  logic           busy_v [NI];
  logic           err_v  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*N-1:0] last_q [NI];
  logic [N-1:0]   last_r [NI];
  logic           last_e [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reciprocal_divider #(.N(N), .BPC(1 << g)) u_dut (
      .clock (clock),
      .rst   (rst),
      .req   (req_v[g]),
      .mode  (mode),
      .a     (a),
      .x     (x),
      .x_inv (xinv_v[g]),
      .rem   (rem_v[g]),
      .ack   (ack_v[g]),
      .busy  (busy_v[g]),
      .err   (err_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic m, input logic [N-1:0] av, input logic [N-1:0] xv,
                                output logic [2*N-1:0] q, output logic [N-1:0] r,
                                output logic e);
    int unsigned num;
    if (xv == 0) begin
      q = 16'hFFFF;
      r = 8'h00;
      e = 1'b1;
    end else begin
      num = m ? int'(av) * 256 : 32768;
      q   = 16'(num / int'(xv));
      r   = 8'(num % int'(xv));
      e   = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_retained(input int d, input string tag);
    check($sformatf("d%0d_%s_xinv", d, tag), 32'(xinv_v[d]), 32'(last_q[d]));
    check($sformatf("d%0d_%s_rem", d, tag), 32'(rem_v[d]), 32'(last_r[d]));
    check($sformatf("d%0d_%s_err", d, tag), 32'(err_v[d]), 32'(last_e[d]));
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < NI; d++) begin
      check($sformatf("d%0d_%s_xinv", d, tag), 32'(xinv_v[d]), 32'h0);
      check($sformatf("d%0d_%s_rem", d, tag), 32'(rem_v[d]), 32'h0);
      check($sformatf("d%0d_%s_ack", d, tag), 32'(ack_v[d]), 32'h0);
      check($sformatf("d%0d_%s_busy", d, tag), 32'(busy_v[d]), 32'h0);
      check($sformatf("d%0d_%s_err", d, tag), 32'(err_v[d]), 32'h0);
    end
  endtask

  // One full handshake on instance d; inputs are scrambled after capture.
  task automatic do_op(input int d, input logic m, input logic [N-1:0] av, input logic [N-1:0] xv);
    logic [2*N-1:0] eq;
    logic [N-1:0]   er;
    logic           ee;
    int             lat;
    int             edge_no;
    int             busy_cnt;
    model(m, av, xv, eq, er, ee);
    lat  = (xv == 0) ? 0 : (2 * N) >> d;
    mode = m;
    a    = av;
    x    = xv;
    req_v[d] = 1'b1;
    tick();
    mode = 1'($urandom);
    a    = 8'($urandom);
    x    = 8'($urandom);
    edge_no  = 0;
    busy_cnt = busy_v[d] ? 1 : 0;
    check($sformatf("d%0d_busy_ack_excl", d), 32'(busy_v[d] & ack_v[d]), 32'h0);
    while (!ack_v[d] && edge_no < 64) begin
      tick();
      edge_no++;
      if (busy_v[d]) busy_cnt++;
      check($sformatf("d%0d_busy_ack_excl", d), 32'(busy_v[d] & ack_v[d]), 32'h0);
    end
    if (!ack_v[d]) check($sformatf("d%0d_ack_timeout", d), 32'(ack_v[d]), 32'h1);
    check($sformatf("d%0d_latency", d), 32'(edge_no), 32'(lat));
    check($sformatf("d%0d_busy_cycles", d), 32'(busy_cnt), 32'(lat));
    check($sformatf("d%0d_xinv", d), 32'(xinv_v[d]), 32'(eq));
    check($sformatf("d%0d_rem", d), 32'(rem_v[d]), 32'(er));
    check($sformatf("d%0d_err", d), 32'(err_v[d]), 32'(ee));
    last_q[d] = eq;
    last_r[d] = er;
    last_e[d] = ee;
    // req held: must stay in DONE with stable results.
    repeat (3) begin
      tick();
      check($sformatf("d%0d_hold_ack", d), 32'(ack_v[d]), 32'h1);
      check($sformatf("d%0d_hold_busy", d), 32'(busy_v[d]), 32'h0);
      check($sformatf("d%0d_hold_xinv", d), 32'(xinv_v[d]), 32'(eq));
    end
    req_v[d] = 1'b0;
    tick();
    check($sformatf("d%0d_release_ack", d), 32'(ack_v[d]), 32'h0);
    check_retained(d, "idle");
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b0;
    a    = '0;
    x    = '0;
    for (int d = 0; d < NI; d++) begin
      req_v[d]  = 1'b0;
      last_q[d] = '0;
      last_r[d] = '0;
      last_e[d] = 1'b0;
    end
    #2;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(0, 1'b0, 8'd0, 8'd3);
    do_op(0, 1'b0, 8'd0, 8'd1);
    do_op(0, 1'b0, 8'd0, 8'hFF);
    do_op(0, 1'b0, 8'd0, 8'd0);
    do_op(2, 1'b1, 8'd200, 8'd7);
    do_op(1, 1'b1, 8'd255, 8'd1);
    do_op(2, 1'b1, 8'd17, 8'd0);

    // Abort at CALC step 5
    mode = 1'b0;
    x    = 8'd9;
    req_v[0] = 1'b1;
    tick();
    repeat (5) tick();
    check("abort_busy_before", 32'(busy_v[0]), 32'h1);
    req_v[0] = 1'b0;
    tick();
    check("abort_busy_after", 32'(busy_v[0]), 32'h0);
    check_retained(0, "abort");
    repeat (20) begin
      tick();
      check("abort_no_ack", 32'(ack_v[0]), 32'h0);
    end

    // Reset mid-CALC
    mode = 1'b1;
    a    = 8'd99;
    x    = 8'd5;
    req_v[1] = 1'b1;
    tick();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_all_zero("midcalc_rst");
    req_v[1] = 1'b0;
    rst = 1'b0;
    for (int d = 0; d < NI; d++) begin
      last_q[d] = '0;
      last_r[d] = '0;
      last_e[d] = 1'b0;
    end
    tick();
    check("post_rst_no_ack", 32'(ack_v[1]), 32'h0);
    do_op(1, 1'b1, 8'd99, 8'd5);

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      int   d;
      logic m;
      logic [N-1:0] av;
      logic [N-1:0] xv;
      d  = int'($urandom_range(0, NI - 1));
      m  = 1'($urandom);
      av = 8'($urandom);
      xv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      do_op(d, m, av, xv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reciprocal_divider.md
RECIPROCAL_DIVIDER -- requirements
Module: reciprocal_divider

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the operand width in bits (N >= 2).
REQ-002 The module SHALL have parameter BPC, default 1, giving the quotient bits retired per cycle; legal values are 1, 2 and 4, and BPC SHALL divide 2N.
REQ-003 The module SHALL have port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port `req`, input, 1 bit: operation request, 4-phase handshake.
REQ-006 The module SHALL have port `mode`, input, 1 bit: 0 selects reciprocal, 1 selects division.
REQ-007 The module SHALL have port `a`, input, N bits: dividend, used only when mode=1.
REQ-008 The module SHALL have port `x`, input, N bits: divisor, unsigned.
REQ-009 The module SHALL have port `x_inv`, output, 2N bits: quotient result.
REQ-010 The module SHALL have port `rem`, output, N bits: remainder result.
REQ-011 The module SHALL have port `ack`, output, 1 bit: result valid / handshake acknowledge.
REQ-012 The module SHALL have port `busy`, output, 1 bit: high while state is CALC.
REQ-013 The module SHALL have port `err`, output, 1 bit: divide-by-zero flag, valid while ack=1.

Function
REQ-014 The module SHALL form the numerator NUM (2N bits) as follows: mode=0 gives NUM = 2^(2N-1); mode=1 gives NUM = a * 2^N (a concatenated with N zeros).
REQ-015 The module SHALL produce x_inv = floor(NUM / x) and rem = NUM mod x, both exact for all x != 0; the result always fits in 2N bits without saturation.
REQ-016 The module SHALL compute the result by restoring (shift-subtract) division, MSB first, with BPC quotient bits resolved per CALC cycle; the partial remainder register is N+1 bits.
REQ-017 The module SHALL implement exactly the states IDLE, CALC and DONE, in a registered FSM.
REQ-018 In IDLE with req=1 at a rising edge, the module SHALL capture mode, a and x into internal registers, clear the step counter, and go to CALC; later changes on a, x or mode SHALL NOT affect the operation.
REQ-019 In IDLE with req=1 and x=0, the module SHALL go directly to DONE with err=1, x_inv all ones and rem=0.
REQ-020 In CALC, each edge SHALL retire BPC quotient bits and increment the counter; after the (2N/BPC)-th CALC edge the state SHALL be DONE.
REQ-021 Latency SHALL be as follows: ack SHALL be high after rising edge number 2N/BPC counted from the capture edge (edge 0), which is 16 edges for N=8 and BPC=1, and 4 edges for N=8 and BPC=4.
REQ-022 In DONE, ack SHALL be 1, and x_inv, rem and err SHALL be held stable.
REQ-023 The module SHALL go from DONE to IDLE on the first edge with req=0; ack SHALL fall in the same cycle in which the state leaves DONE.
REQ-024 With req held high in DONE, the module SHALL remain in DONE; a new operation SHALL require req low for at least one edge (no back-to-back re-trigger).
REQ-025 If req falls during CALC (abort), the module SHALL return to IDLE on the next edge, never assert ack for that operation, and leave x_inv, rem and err at their previous values.
REQ-026 busy SHALL be 1 exactly while the state is CALC; busy and ack SHALL never both be 1.
REQ-027 In IDLE, x_inv, rem and err SHALL retain the last completed result.

Reset
REQ-028 When rst=1, the module SHALL immediately (asynchronously) force the state to IDLE, x_inv=0, rem=0, ack=0, busy=0, err=0, and clear the counter and operand registers.
REQ-029 If rst asserts mid-CALC or in DONE, the module SHALL abandon the operation without producing ack; after rst is released it SHALL accept a new req on the first edge that sees req=1.

Verification
REQ-030 The bench SHALL check: N=8, BPC=1, mode=0, x=3, req held -> ack after 16 edges, x_inv=0x2AAA, rem=0x02, err=0, busy high for 16 cycles.
REQ-031 The bench SHALL check: N=8, mode=0, x=1 -> x_inv=0x8000, rem=0; and x=0xFF -> x_inv=0x0080, rem=0x80.
REQ-032 The bench SHALL check: N=8, BPC=4, mode=1, a=200, x=7 -> ack after 4 edges, x_inv=0x1C92 (7314), rem=0x02.
REQ-033 The bench SHALL check: x=0, req=1 -> ack on the next edge, err=1, x_inv=0xFFFF, rem=0, busy never high.
REQ-034 The bench SHALL check abort and reset: req dropped at CALC step 5 -> IDLE next edge, no ack, outputs unchanged; rst pulsed mid-CALC -> all outputs 0 at once, and the next request completes correctly.
REQ-035 The bench SHALL check the handshake: req held high after ack -> state stays DONE with no re-trigger; req low for 1 edge then high -> a new result; a and x changed during CALC -> result uses the captured values.
